serial_subtractor: RTL and testbench

//   Bit-serial subtractor: computes a - b one bit per clock, LSB first, using a

---
 rtl/serial_subtractor.sv | 130 +++++++++++++
 tb/tb_serial_subtractor.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one full-subtractor cell plus a registered borrow
// produce a - b LSB first, one bit per clock, with a done pulse at the end.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [WIDTH-1:0] ra_r;
  logic [WIDTH-1:0] rb_r;
  logic             br_r;
  logic [CW-1:0]    count_r;
  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic             bo_s;
  logic             busy_s;
  logic             done_s;
  logic [WIDTH-1:0] shift_s;

  // Full-subtractor cell on the current LSBs and the carried borrow.
  always_comb begin
    d_s      = ra_r[0] ^ rb_r[0] ^ br_r;
    bo_s     = (~ra_r[0] & rb_r[0]) | (~(ra_r[0] ^ rb_r[0]) & br_r);
    last_s   = (count_r == LAST);
    accept_s = ((state_r == IDLE) || (state_r == DONE)) && start;
  end

  // Difference bits enter at the top of the minuend register as its bits are
  // consumed, so after WIDTH steps it holds the complete result.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shift_s = d_s;
    end else begin : g_wn
      assign shift_s = {d_s, ra_r[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (start) state_s = RUN;
        else       state_s = IDLE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Output decode from the next state so busy/done come straight from flops.
  always_comb begin
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // Registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_s;
      done <= done_s;
    end
  end

  // Operand capture, serial bit step and result capture on the final bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_r    <= {WIDTH{1'b0}};
      rb_r    <= {WIDTH{1'b0}};
      br_r    <= 1'b0;
      count_r <= {CW{1'b0}};
      diff    <= {WIDTH{1'b0}};
      borrow  <= 1'b0;
    end else if (accept_s) begin
      ra_r    <= a;
      rb_r    <= b;
      br_r    <= 1'b0;
      count_r <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      ra_r    <= shift_s;
      rb_r    <= rb_r >> 1;
      br_r    <= bo_s;
      count_r <= count_r + CW'(1);
      if (last_s) begin
        diff   <= shift_s;
        borrow <= bo_s;
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 13 and 1: directed
// cases plus randomized operations against an arithmetic reference.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  logic        st8, busy8, done8, borrow8;
  logic [7:0]  a8, b8, diff8;
  logic        st13, busy13, done13, borrow13;
  logic [12:0] a13, b13, diff13;
  logic        st1, busy1, done1, borrow1;
  logic        a1, b1, diff1;

  int          sel;
  logic        busy_m, done_m, borrow_m;
  logic [15:0] diff_m;

  int          checks;
  int          errors;
  logic [15:0] last_d;
  logic        last_b;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(st13), .a(a13), .b(b13),
    .busy(busy13), .done(done13), .diff(diff13), .borrow(borrow13)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow(borrow1)
  );

  always #5 clk = ~clk;

  // Route the outputs of the instance under test to one set of signals.
  always_comb begin
    busy_m = 1'b0; done_m = 1'b0; borrow_m = 1'b0; diff_m = 16'h0000;
    case (sel)
      8:  begin busy_m = busy8;  done_m = done8;  borrow_m = borrow8;  diff_m = {8'h00, diff8};   end
      13: begin busy_m = busy13; done_m = done13; borrow_m = borrow13; diff_m = {3'b000, diff13}; end
      1:  begin busy_m = busy1;  done_m = done1;  borrow_m = borrow1;  diff_m = {15'h0000, diff1}; end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [16:0] ref_sub(input int w, input logic [15:0] av, input logic [15:0] bv);
    logic [16:0] mask;
    logic [16:0] r;
    mask = (17'd1 << w) - 17'd1;
    r = ({1'b0, av} & mask) - ({1'b0, bv} & mask);
    return {r[16], r[15:0] & mask[15:0]};
  endfunction

  task automatic set_in(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv);
    case (w)
      8:  begin st8  = st; a8  = 8'(av);  b8  = 8'(bv);  end
      13: begin st13 = st; a13 = 13'(av); b13 = 13'(bv); end
      1:  begin st1  = st; a1  = 1'(av);  b1  = 1'(bv);  end
      default: ;
    endcase
  endtask

  // Called right after start was raised on a falling edge; follows the op to done.
  task automatic collect(input int w, input int inj, input bit chk_hold,
                         input logic [15:0] pd, input logic pb,
                         output int nbusy, output bit got);
    nbusy = 0;
    got   = 1'b0;
    @(negedge clk);
    set_in(w, 1'b0, 16'($urandom), 16'($urandom));
    for (int i = 0; i < w + 4; i++) begin
      check("busy_done_excl", 32'(busy_m & done_m), 32'd0);
      if (done_m) begin
        got = 1'b1;
        break;
      end
      if (busy_m) nbusy++;
      if (chk_hold) begin
        check("hold_diff", 32'(diff_m), 32'(pd));
        check("hold_borrow", 32'(borrow_m), 32'(pb));
      end
      if (i + 1 == inj) set_in(w, 1'b1, 16'h00FF, 16'h0000);
      else              set_in(w, 1'b0, 16'($urandom), 16'($urandom));
      @(negedge clk);
    end
  endtask

  task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input int inj, input bit chain);
    logic [16:0] e;
    int          nb;
    bit          got;
    e   = ref_sub(w, av, bv);
    sel = w;
    set_in(w, 1'b1, av, bv);
    collect(w, inj, chain, last_d, last_b, nb, got);
    check("done_seen", 32'(got), 32'd1);
    check("busy_cycles", nb, w);
    check("diff", 32'(diff_m), 32'(e[15:0]));
    check("borrow", 32'(borrow_m), 32'(e[16]));
    last_d = e[15:0];
    last_b = e[16];
  endtask

  task automatic finish_idle();
    @(negedge clk);
    check("done_one_pulse", 32'(done_m), 32'd0);
    check("idle_busy", 32'(busy_m), 32'd0);
  endtask

  initial begin
    bit seen;
    bit ch;
    int ws [3];
    clk = 1'b0; rst = 1'b1; sel = 8;
    checks = 0; errors = 0; last_d = 16'h0000; last_b = 1'b0;
    st8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    st13 = 1'b0; a13 = 13'h0000; b13 = 13'h0000;
    st1 = 1'b0; a1 = 1'b0; b1 = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_diff", 32'(diff_m), 32'd0);
    check("rst_borrow", 32'(borrow_m), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8, 16'h0035, 16'h0012, 0, 1'b0); finish_idle();
    do_op(8, 16'h0000, 16'h0001, 0, 1'b0); finish_idle();
    do_op(8, 16'h00AA, 16'h00AA, 0, 1'b0); finish_idle();
    // start pulsed during the third RUN cycle must be ignored
    do_op(8, 16'h0010, 16'h0020, 3, 1'b0); finish_idle();
    check("ignored_start_diff", 32'(diff_m), 32'h0000_00F0);

    // asynchronous reset in the middle of the fifth RUN cycle
    set_in(8, 1'b1, 16'h005A, 16'h0013);
    @(negedge clk);
    set_in(8, 1'b0, 16'h0000, 16'h0000);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy_m), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy_m), 32'd0);
    check("abort_done", 32'(done_m), 32'd0);
    check("abort_diff", 32'(diff_m), 32'd0);
    check("abort_borrow", 32'(borrow_m), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_m || busy_m) seen = 1'b1;
    end
    check("no_done_after_abort", 32'(seen), 32'd0);
    last_d = 16'h0000; last_b = 1'b0;
    do_op(8, 16'h005A, 16'h0013, 0, 1'b0); finish_idle();

    // back-to-back: next start presented while done is high
    do_op(8, 16'h0040, 16'h0001, 0, 1'b0);
    do_op(8, 16'h0080, 16'h007F, 0, 1'b1); finish_idle();

    do_op(1, 16'h0000, 16'h0001, 0, 1'b0); finish_idle();

    ws[0] = 8; ws[1] = 13; ws[2] = 1;
    foreach (ws[k]) begin
      for (int n = 0; n < 20; n++) begin
        ch = (n > 0) && (ws[k] != 1 || n > 1) && ($urandom_range(0, 1) == 1);
        do_op(ws[k], 16'($urandom), 16'($urandom), 0, ch);
        if ($urandom_range(0, 2) != 0) finish_idle();
        else if (n == 19) finish_idle();
        else begin
          // chain the next op straight from DONE
          n++;
          do_op(ws[k], 16'($urandom), 16'($urandom), 0, 1'b1);
          finish_idle();
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
